// File: rtl/e_mdu.sv
// -----------------------------------------------------------------------------
// e_mdu - execute-stage multiply/divide unit, owner of the HI/LO registers.
//
// A mult/multu/div/divu accepted in IDLE computes its result immediately into
// shadow registers. It then holds E_busy for a fixed number of cycles, which
// models the latency of a multicycle datapath. On the last busy edge the shadow
// values are committed to HI/LO. mfhi/mflo read HI/LO combinationally, and
// mthi/mtlo write them while the unit is idle.
//
// Ports:
//   clk          pipeline clock
//   reset_n      asynchronous active-low reset
//   E_MDU_op     opcode in E (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-31 none)
//   E_rs_val     forwarded rs operand
//   E_rt_val     forwarded rt operand
//   E_MDU_out    HI for mfhi, LO for mflo, otherwise 0 (combinational)
//   E_busy       registered, high while an operation is in flight
//   E_start      high when a mult/div op is presented while idle
//   E_real_busy  E_start | E_busy, consumed by the stall controller
// -----------------------------------------------------------------------------
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  E_MDU_op,
  input  logic [31:0] E_rs_val,
  input  logic [31:0] E_rt_val,
  output logic [31:0] E_MDU_out,
  output logic        E_busy,
  output logic        E_start,
  output logic        E_real_busy
);

  localparam logic [4:0] OP_MULT  = 5'd1;
  localparam logic [4:0] OP_MULTU = 5'd2;
  localparam logic [4:0] OP_DIV   = 5'd3;
  localparam logic [4:0] OP_DIVU  = 5'd4;
  localparam logic [4:0] OP_MFHI  = 5'd5;
  localparam logic [4:0] OP_MFLO  = 5'd6;
  localparam logic [4:0] OP_MTHI  = 5'd7;
  localparam logic [4:0] OP_MTLO  = 5'd8;

  localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
  localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_s_q, hi_s_d;
  logic [31:0] lo_s_q, lo_s_d;

  logic        is_arith_s;
  logic [63:0] mul_a_s, mul_b_s, prod_s;
  logic        neg_a_s, neg_b_s;
  logic [31:0] mag_a_s, mag_b_s, divisor_s;
  logic [31:0] qmag_s, rmag_s, quot_s, rem_s;
  logic [31:0] res_hi_s, res_lo_s;

  // Decode of the mult/div group and the start handshake.
  always_comb begin
    is_arith_s  = (E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU) ||
                  (E_MDU_op == OP_DIV)  || (E_MDU_op == OP_DIVU);
    E_busy      = (state_q == ST_RUN);
    E_start     = is_arith_s && !E_busy;
    E_real_busy = E_start || E_busy;
  end

  // Result datapath: product and sign-corrected quotient/remainder.
  always_comb begin
    // Signed multiply = low 64 bits of the product of sign-extended operands.
    if (E_MDU_op == OP_MULTU) begin
      mul_a_s = {32'd0, E_rs_val};
      mul_b_s = {32'd0, E_rt_val};
    end else begin
      mul_a_s = {{32{E_rs_val[31]}}, E_rs_val};
      mul_b_s = {{32{E_rt_val[31]}}, E_rt_val};
    end
    prod_s = mul_a_s * mul_b_s;

    // Divide on magnitudes and then fix the signs. 0x80000000 / -1 falls out
    // naturally because the magnitude 0x80000000 negates to itself.
    neg_a_s   = (E_MDU_op == OP_DIV) && E_rs_val[31];
    neg_b_s   = (E_MDU_op == OP_DIV) && E_rt_val[31];
    mag_a_s   = neg_a_s ? (32'd0 - E_rs_val) : E_rs_val;
    mag_b_s   = neg_b_s ? (32'd0 - E_rt_val) : E_rt_val;
    // A zero divisor is replaced so that the divider never produces X.
    // The result it gives in that case is discarded below.
    divisor_s = (mag_b_s == 32'd0) ? 32'd1 : mag_b_s;
    qmag_s    = mag_a_s / divisor_s;
    rmag_s    = mag_a_s % divisor_s;
    quot_s    = (neg_a_s ^ neg_b_s) ? (32'd0 - qmag_s) : qmag_s;
    rem_s     = neg_a_s ? (32'd0 - rmag_s) : rmag_s;

    case (E_MDU_op)
      OP_MULT, OP_MULTU: begin
        res_hi_s = prod_s[63:32];
        res_lo_s = prod_s[31:0];
      end
      OP_DIV, OP_DIVU: begin
        // Divide by zero snapshots the current HI/LO. Because HI/LO cannot
        // change while busy, the commit then rewrites them unchanged.
        if (E_rt_val == 32'd0) begin
          res_hi_s = hi_q;
          res_lo_s = lo_q;
        end else begin
          res_hi_s = rem_s;
          res_lo_s = quot_s;
        end
      end
      default: begin
        res_hi_s = hi_q;
        res_lo_s = lo_q;
      end
    endcase
  end

  // mfhi/mflo read port, with no bypass of an in-flight result.
  always_comb begin
    case (E_MDU_op)
      OP_MFHI: E_MDU_out = hi_q;
      OP_MFLO: E_MDU_out = lo_q;
      default: E_MDU_out = 32'd0;
    endcase
  end

  // Next-state logic: start, countdown/commit, and the mthi/mtlo writes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_s_d  = hi_s_q;
    lo_s_d  = lo_s_q;
    case (state_q)
      ST_IDLE: begin
        if (E_start) begin
          state_d = ST_RUN;
          cnt_d   = ((E_MDU_op == OP_MULT) || (E_MDU_op == OP_MULTU)) ? MULT_LOAD : DIV_LOAD;
          hi_s_d  = res_hi_s;
          lo_s_d  = res_lo_s;
        end else if (E_MDU_op == OP_MTHI) begin
          hi_d = E_rs_val;
        end else if (E_MDU_op == OP_MTLO) begin
          lo_d = E_rs_val;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = ST_IDLE;
          hi_d    = hi_s_q;
          lo_d    = lo_s_q;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State, counter, HI/LO and shadow registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      hi_s_q  <= 32'd0;
      lo_s_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_s_q  <= hi_s_d;
      lo_s_q  <= lo_s_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// -----------------------------------------------------------------------------
// tb_e_mdu - self-checking bench for e_mdu.
// A behavioural model tracks HI/LO and records the cycle number at which an
// accepted operation commits. A negedge compare process checks every DUT
// output against the model on every cycle. Directed scenarios pin the model
// with literal values, and they are followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_e_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  E_MDU_op;
  logic [31:0] E_rs_val, E_rt_val, E_MDU_out;
  logic        E_busy, E_start, E_real_busy;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .E_MDU_op   (E_MDU_op),
    .E_rs_val   (E_rs_val),
    .E_rt_val   (E_rt_val),
    .E_MDU_out  (E_MDU_out),
    .E_busy     (E_busy),
    .E_start    (E_start),
    .E_real_busy(E_real_busy)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;
  bit check_en = 1'b0;

  // Model state
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  bit          m_inflight, m_pend_wr;
  int          cyc, m_commit_at;

  // Expected outputs for the current cycle
  logic [31:0] exp_out;
  logic        exp_busy, exp_start, exp_real;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare process: every cycle, mid-period, against the model.
  always @(negedge clk) begin
    if (check_en) begin
      check32("busy",      32'(E_busy),      32'(exp_busy));
      check32("start",     32'(E_start),     32'(exp_start));
      check32("real_busy", 32'(E_real_busy), 32'(exp_real));
      check32("mdu_out",   E_MDU_out,        exp_out);
    end
  end

  // Architectural result of an arithmetic op, as plain 64-bit arithmetic.
  task automatic model_compute(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    m_pend_wr = 1'b1;
    case (op)
      5'd1: begin sp = sa * sb; m_pend_hi = 32'(sp >>> 32); m_pend_lo = 32'(sp); end
      5'd2: begin up = ua * ub; m_pend_hi = 32'(up >> 32);  m_pend_lo = 32'(up); end
      5'd3: begin
        if (b == 32'd0) m_pend_wr = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; m_pend_lo = 32'(sq); m_pend_hi = 32'(sr); end
      end
      default: begin
        if (b == 32'd0) m_pend_wr = 1'b0;
        else begin m_pend_lo = 32'(ua / ub); m_pend_hi = 32'(ua % ub); end
      end
    endcase
  endtask

  // One pipeline cycle: apply inputs, set expectations, then advance the model.
  task automatic step(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    E_MDU_op  = op;
    E_rs_val  = a;
    E_rt_val  = b;
    exp_busy  = m_inflight;
    exp_start = (op >= 5'd1) && (op <= 5'd4) && !m_inflight;
    exp_real  = exp_start || exp_busy;
    exp_out   = (op == 5'd5) ? m_hi : (op == 5'd6) ? m_lo : 32'd0;
    @(negedge clk);
    @(posedge clk);
    if (m_inflight) begin
      if (cyc == m_commit_at) begin
        m_inflight = 1'b0;
        if (m_pend_wr) begin
          m_hi = m_pend_hi;
          m_lo = m_pend_lo;
        end
      end
    end else if (exp_start) begin
      m_inflight  = 1'b1;
      m_commit_at = cyc + ((op <= 5'd2) ? MC : DC);
      model_compute(op, a, b);
    end else if (op == 5'd7) begin
      m_hi = a;
    end else if (op == 5'd8) begin
      m_lo = a;
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(5'd0, $urandom, $urandom);
  endtask

  task automatic read_back();
    step(5'd5, 32'd0, 32'd0);
    step(5'd6, 32'd0, 32'd0);
  endtask

  // Asynchronous reset between clock edges; the outputs must clear at once.
  task automatic reset_mid();
    check_en = 1'b0;
    E_MDU_op = 5'd0;
    #2 reset_n = 1'b0;
    #1;
    check32("rst_async_busy", 32'(E_busy), 32'd0);
    check32("rst_async_real", 32'(E_real_busy), 32'd0);
    m_hi = 32'd0; m_lo = 32'd0; m_inflight = 1'b0;
    @(negedge clk);
    E_MDU_op = 5'd5; #1 check32("rst_mfhi", E_MDU_out, 32'd0);
    E_MDU_op = 5'd6; #1 check32("rst_mflo", E_MDU_out, 32'd0);
    E_MDU_op = 5'd0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    cyc = 0; m_hi = 32'd0; m_lo = 32'd0; m_inflight = 1'b0; m_pend_wr = 1'b0;
    m_pend_hi = 32'd0; m_pend_lo = 32'd0; m_commit_at = 0;
    E_MDU_op = 5'd0; E_rs_val = 32'd0; E_rt_val = 32'd0;
    reset_n = 1'b0;
    #3;
    check32("init_busy", 32'(E_busy), 32'd0);
    check32("init_real", 32'(E_real_busy), 32'd0);
    E_MDU_op = 5'd5; #1 check32("init_mfhi", E_MDU_out, 32'd0);
    E_MDU_op = 5'd6; #1 check32("init_mflo", E_MDU_out, 32'd0);
    E_MDU_op = 5'd0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_en = 1'b1;

    // mult -1 * 2; the operands change while busy and must have no effect
    step(5'd1, 32'hFFFF_FFFF, 32'd2);
    idle(MC - 1);
    check32("pin_lat_still_busy", 32'(m_inflight), 32'd1);
    idle(1);
    check32("pin_lat_done", 32'(m_inflight), 32'd0);
    read_back();
    check32("pin_mult_hi", m_hi, 32'hFFFF_FFFF);
    check32("pin_mult_lo", m_lo, 32'hFFFF_FFFE);

    // multu with the same operands
    step(5'd2, 32'hFFFF_FFFF, 32'd2);
    idle(MC);
    read_back();
    check32("pin_multu_hi", m_hi, 32'h0000_0001);
    check32("pin_multu_lo", m_lo, 32'hFFFF_FFFE);

    // div -7 / 2
    step(5'd3, 32'hFFFF_FFF9, 32'd2);
    idle(DC);
    read_back();
    check32("pin_div_hi", m_hi, 32'hFFFF_FFFF);
    check32("pin_div_lo", m_lo, 32'hFFFF_FFFD);

    // divu by zero leaves HI/LO unchanged
    step(5'd7, 32'h11, 32'd0);
    step(5'd8, 32'h22, 32'd0);
    step(5'd4, 32'd7, 32'd0);
    idle(DC);
    read_back();
    check32("pin_dz_hi", m_hi, 32'h11);
    check32("pin_dz_lo", m_lo, 32'h22);

    // mthi in idle, readable next cycle
    step(5'd7, 32'hABCD, 32'd0);
    step(5'd5, 32'd0, 32'd0);
    check32("pin_mthi", m_hi, 32'hABCD);

    // mtlo during RUN is ignored
    step(5'd1, 32'd3, 32'd5);
    step(5'd8, 32'h5555, 32'd0);
    step(5'd6, 32'd0, 32'd0);
    idle(MC - 2);
    read_back();
    check32("pin_mtlo_run_lo", m_lo, 32'd15);
    check32("pin_mtlo_run_hi", m_hi, 32'd0);

    // Signed overflow case of div
    step(5'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DC);
    read_back();
    check32("pin_divovf_lo", m_lo, 32'h8000_0000);
    check32("pin_divovf_hi", m_hi, 32'd0);

    // Reset asserted in cycle T+2 of a mult
    step(5'd1, 32'h1234, 32'h5678);
    step(5'd0, 32'd0, 32'd0);
    reset_mid();
    read_back();

    // Randomized traffic, including ops issued while busy and ops 9-31
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 9) < 8) ? 5'($urandom_range(0, 8)) : 5'($urandom_range(9, 31));
      step(op, pick_operand(), pick_operand());
    end
    idle(DC + 1);
    read_back();

    check_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
